// File: rtl/csa_resolve_adder.sv
// csa_resolve_adder: two-stage valid/ready carry-propagate adder that resolves a redundant (sum, carry)
// pair into one 64-bit word or two independent 32-bit lanes. Define CSA_RESOLVE_CARRY_OUT_EN for CARRY_OUT.
module csa_resolve_adder #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LO_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode64,
  input  logic [DATA_W-1:0] SUM_IN,
  input  logic [DATA_W-1:0] CARRY_IN,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] RESULT,
  output logic              out_valid,
  input  logic              out_ready
`ifdef CSA_RESOLVE_CARRY_OUT_EN
  ,
  output logic [1:0]        CARRY_OUT
`endif
);

  localparam int unsigned HI_W = DATA_W - LO_W;

  logic            va;
  logic            vb;
  logic            adv_b;
  logic            load_a;
  logic            load_b;
  logic            c32;
  logic [LO_W:0]   lo_add;
  logic [HI_W:0]   hi_add;

  // Stage A registers: resolved low half plus the high-half operands travelling with their mode
  logic [LO_W-1:0] a_lo;
  logic            a_lo_co;
  logic            a_mode;
  logic [HI_W-1:0] a_hi_s;
  logic [HI_W-1:0] a_hi_c;

  // Handshake and both half-width adders
  always_comb begin
    adv_b    = !vb || out_ready;
    in_ready = !rst && (!va || adv_b);
    load_a   = in_valid && in_ready;
    load_b   = va && adv_b;
    lo_add   = {1'b0, SUM_IN[LO_W-1:0]} + {1'b0, CARRY_IN[LO_W-1:0]};
    // Lane mode blocks the bit-31 carry from reaching the high half
    c32      = a_mode && a_lo_co;
    hi_add   = {1'b0, a_hi_s} + {1'b0, a_hi_c} + (HI_W+1)'(c32);
  end

  assign out_valid = vb;

  // Stage A: capture only on an accepted input so idle inputs never reach the pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      va      <= 1'b0;
      a_lo    <= '0;
      a_lo_co <= 1'b0;
      a_mode  <= 1'b0;
      a_hi_s  <= '0;
      a_hi_c  <= '0;
    end else begin
      if (load_a) begin
        va      <= 1'b1;
        a_lo    <= lo_add[LO_W-1:0];
        a_lo_co <= lo_add[LO_W];
        a_mode  <= mode64;
        a_hi_s  <= SUM_IN[DATA_W-1:LO_W];
        a_hi_c  <= CARRY_IN[DATA_W-1:LO_W];
      end else if (load_b) begin
        va <= 1'b0;
      end
    end
  end

  // Stage B: output register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vb     <= 1'b0;
      RESULT <= '0;
    end else begin
      if (load_b) begin
        vb     <= 1'b1;
        RESULT <= {hi_add[HI_W-1:0], a_lo};
      end else if (out_ready) begin
        vb <= 1'b0;
      end
    end
  end

`ifdef CSA_RESOLVE_CARRY_OUT_EN
  // Bit 0 reports the low-lane carry only in lane mode; in 64-bit mode it was consumed internally
  always_ff @(posedge clk) begin
    if (rst) begin
      CARRY_OUT <= 2'b00;
    end else if (load_b) begin
      CARRY_OUT <= {hi_add[HI_W], a_lo_co && !a_mode};
    end
  end
`endif

endmodule

// File: tb/tb_csa_resolve_adder.sv
// tb_csa_resolve_adder: randomized and directed bench for csa_resolve_adder against a plain-arithmetic model.
// Carry-out checks are included when CSA_RESOLVE_CARRY_OUT_EN is defined.
module tb_csa_resolve_adder;

  typedef struct packed {
    logic [63:0] res;
    logic [1:0]  co;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode64 = 1'b0;
  logic [63:0] sum_in = '0;
  logic [63:0] carry_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] result;
  logic        out_valid;
  logic        out_ready = 1'b0;
`ifdef CSA_RESOLVE_CARRY_OUT_EN
  logic [1:0]  carry_out;
`endif

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  csa_resolve_adder dut (
    .clk       (clk),
    .rst       (rst),
    .mode64    (mode64),
    .SUM_IN    (sum_in),
    .CARRY_IN  (carry_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .RESULT    (result),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef CSA_RESOLVE_CARRY_OUT_EN
    ,
    .CARRY_OUT (carry_out)
`endif
  );

  always #5 clk = ~clk;

  // Reference: full-width add for 64-bit mode, two independent 33-bit adds for lane mode
  function automatic exp_t model(input logic m, input logic [63:0] s, input logic [63:0] c);
    exp_t        e;
    logic [64:0] full;
    logic [32:0] lo;
    logic [32:0] hi;
    full = {1'b0, s} + {1'b0, c};
    lo   = {1'b0, s[31:0]} + {1'b0, c[31:0]};
    hi   = {1'b0, s[63:32]} + {1'b0, c[63:32]};
    if (m) begin
      e.res = full[63:0];
      e.co  = {full[64], 1'b0};
    end else begin
      e.res = {hi[31:0], lo[31:0]};
      e.co  = {hi[32], lo[32]};
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_operands(output logic [63:0] s, output logic [63:0] c);
    s = {$urandom, $urandom};
    c = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) begin
      s[31:0] = '1;
      c[31:0] = 32'd1;
    end
    if ($urandom_range(0, 3) == 0) s[63:32] = ~c[63:32];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if (result !== 64'd0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
`ifdef CSA_RESOLVE_CARRY_OUT_EN
    total++;
    if (carry_out !== 2'b00) begin bad++; $display("FAIL reset_carry_out: got %b want 00", carry_out); end
`endif
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic        vm[4];
    logic [63:0] vs[4];
    logic [63:0] vc[4];
    logic [63:0] vr[4];
    logic [1:0]  vco[4];
    vm[0] = 1'b1; vs[0] = 64'h0000_0000_FFFF_FFFF; vc[0] = 64'd1; vr[0] = 64'h0000_0001_0000_0000; vco[0] = 2'b00;
    vm[1] = 1'b0; vs[1] = 64'h0000_0000_FFFF_FFFF; vc[1] = 64'd1; vr[1] = 64'h0;                   vco[1] = 2'b01;
    vm[2] = 1'b1; vs[2] = 64'hFFFF_FFFF_FFFF_FFFF; vc[2] = 64'd1; vr[2] = 64'h0;                   vco[2] = 2'b10;
    vm[3] = 1'b0; vs[3] = 64'hFFFF_FFFF_FFFF_FFFF; vc[3] = 64'h0000_0001_0000_0001; vr[3] = 64'h0; vco[3] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      mode64 = vm[i];
      sum_in = vs[i];
      carry_in = vc[i];
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready); end
      tick();
      in_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_latency1: out_valid got %b want 0", i, out_valid); end
      tick();
      #1;
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_latency2: out_valid got %b want 1", i, out_valid); end
      total++;
      if (result !== vr[i]) begin bad++; $display("FAIL dir%0d_result: got %h want %h", i, result, vr[i]); end
`ifdef CSA_RESOLVE_CARRY_OUT_EN
      total++;
      if (carry_out !== vco[i]) begin bad++; $display("FAIL dir%0d_carry_out: got %b want %b", i, carry_out, vco[i]); end
`endif
      tick();
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [63:0] s;
    logic [63:0] c;
    for (int t = 0; t < 6; t++) begin
      out_ready = 1'b1;
      if (t < 4) begin
        rand_operands(s, c);
        mode64 = (t % 2 == 0);
        sum_in = s;
        carry_in = c;
        in_valid = 1'b1;
        exp_q.push_back(model(mode64, s, c));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (t < 4) begin
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b%0d_in_ready: got %b want 1", t, in_ready); end
      end
      if (t < 2) begin
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b%0d_out_valid: got %b want 0", t, out_valid); end
      end else begin
        e = exp_q.pop_front();
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b%0d_out_valid: got %b want 1", t, out_valid); end
        total++;
        if (result !== e.res) begin bad++; $display("FAIL b2b%0d_result: got %h want %h", t, result, e.res); end
`ifdef CSA_RESOLVE_CARRY_OUT_EN
        total++;
        if (carry_out !== e.co) begin bad++; $display("FAIL b2b%0d_carry_out: got %b want %b", t, carry_out, e.co); end
`endif
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic        wm[3];
    logic [63:0] ws[3];
    logic [63:0] wc[3];
    logic [63:0] held = '0;
    logic        have_held = 1'b0;
    exp_t        e;
    int          idx = 0;
    int          popped = 0;
    int          cyc = 0;
    for (int i = 0; i < 3; i++) begin
      wm[i] = 1'($urandom_range(0, 1));
      rand_operands(ws[i], wc[i]);
    end
    while ((idx < 3 || exp_q.size() != 0) && cyc < 30) begin
      out_ready = (cyc >= 5);
      if (idx < 3) begin
        in_valid = 1'b1;
        mode64 = wm[idx];
        sum_in = ws[idx];
        carry_in = wc[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 4) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready: got %b want 0", in_ready); end
        total++;
        if (idx != 2) begin bad++; $display("FAIL bp_accepts: got %0d want 2", idx); end
      end
      if (!out_ready && out_valid) begin
        if (have_held) begin
          total++;
          if (result !== held) begin bad++; $display("FAIL bp_stable: got %h want %h", result, held); end
        end else begin
          held = result;
          have_held = 1'b1;
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL bp_extra_word: got %h want none", result);
        end else begin
          e = exp_q.pop_front();
          if (result !== e.res) begin bad++; $display("FAIL bp_result%0d: got %h want %h", popped, result, e.res); end
`ifdef CSA_RESOLVE_CARRY_OUT_EN
          total++;
          if (carry_out !== e.co) begin bad++; $display("FAIL bp_carry_out%0d: got %b want %b", popped, carry_out, e.co); end
`endif
        end
        popped++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(mode64, sum_in, carry_in));
        idx++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (popped != 3 || cyc >= 30) begin bad++; $display("FAIL bp_drain: got %0d words in %0d cycles want 3", popped, cyc); end
  endtask

  task automatic test_random();
    exp_t        e;
    logic [63:0] s;
    logic [63:0] c;
    int          cyc = 0;
    int          popped = 0;
    while ((cyc < 300 || exp_q.size() != 0) && cyc < 340) begin
      if (cyc < 300) begin
        out_ready = ($urandom_range(0, 3) != 0);
        in_valid = ($urandom_range(0, 3) != 0);
        rand_operands(s, c);
        mode64 = 1'($urandom_range(0, 1));
        sum_in = s;
        carry_in = c;
      end else begin
        out_ready = 1'b1;
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rnd_extra_word: got %h want none", result);
        end else begin
          e = exp_q.pop_front();
          if (result !== e.res) begin bad++; $display("FAIL rnd_result%0d: got %h want %h", popped, result, e.res); end
`ifdef CSA_RESOLVE_CARRY_OUT_EN
          total++;
          if (carry_out !== e.co) begin bad++; $display("FAIL rnd_carry_out%0d: got %b want %b", popped, carry_out, e.co); end
`endif
        end
        popped++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(mode64, sum_in, carry_in));
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (exp_q.size() != 0 || popped == 0) begin
      bad++;
      $display("FAIL rnd_drain: got %0d pending, %0d popped want 0 pending", exp_q.size(), popped);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    logic [63:0] s;
    logic [63:0] c;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_operands(s, c);
      s[0] = 1'b1;
      mode64 = 1'($urandom_range(0, 1));
      sum_in = s;
      carry_in = c;
      in_valid = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL mid%0d_in_ready: got %b want 1", i, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_full_in_ready: got %b want 0", in_ready); end
    rst = 1'b1;
    tick();
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
    total++;
    if (result !== 64'd0) begin bad++; $display("FAIL mid_rst_result: got %h want 0", result); end
`ifdef CSA_RESOLVE_CARRY_OUT_EN
    total++;
    if (carry_out !== 2'b00) begin bad++; $display("FAIL mid_rst_carry_out: got %b want 00", carry_out); end
`endif
    rst = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale%0d: out_valid got %b want 0", t, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
